// File: rtl/data_memory_controller.sv
// Load/store sequencer: accepts one execute-stage access, runs it over a word-addressed
// byte-enabled req/gnt/rvalid bus and returns aligned, extended load data with an error flag.
module data_memory_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_byte_enable,
    output logic [29:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA, RESPOND} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  width_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_error_q;

    function automatic logic illegal_access(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'd0:    illegal_access = 1'b0;
            2'd1:    illegal_access = off[0];
            2'd2:    illegal_access = (off != 2'd0);
            default: illegal_access = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'd0:    lane_enable = 4'b0001 << off;
            2'd1:    lane_enable = off[1] ? 4'b1100 : 4'b0011;
            default: lane_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_store(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'd0:    replicate_store = {4{d[7:0]}};
            2'd1:    replicate_store = {2{d[15:0]}};
            default: replicate_store = d;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0] width, input logic [1:0] off,
                                                input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            2'd0:    extend_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    extend_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extend_load = word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            width_q      <= 2'd0;
            off_q        <= 2'd0;
            uns_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 30'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        width_q     <= req_width;
                        off_q       <= req_address[1:0];
                        uns_q       <= req_unsigned;
                        mem_we_q    <= req_write;
                        mem_be_q    <= lane_enable(req_width, req_address[1:0]);
                        mem_addr_q  <= req_address[31:2];
                        mem_wdata_q <= replicate_store(req_width, req_write_data);
                        cnt_q       <= 8'd0;
                        resp_data_q <= 32'd0;
                        if (illegal_access(req_width, req_address[1:0])) begin
                            state_q      <= RESPOND;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else begin
                            state_q   <= REQUEST;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    // A grant in the final tolerated cycle still wins over the timeout.
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q      <= RESPOND;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b0;
                        end else begin
                            state_q <= WAIT_DATA;
                            cnt_q   <= cnt_q + 8'd1;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        mem_req_q    <= 1'b0;
                        state_q      <= RESPOND;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT_DATA: begin
                    if (mem_rvalid) begin
                        state_q      <= RESPOND;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_data_q  <= extend_load(width_q, off_q, uns_q, mem_read_data);
                    end else if (cnt_q == TO_LAST) begin
                        state_q      <= RESPOND;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= 32'd0;
                    resp_error_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign stall           = (state_q != IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_error      = resp_error_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_address     = mem_addr_q;
    assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: a bus responder with programmable grant and
// read-data delays, expected responses queued at issue and popped when resp_valid fires.
module tb_data_memory_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_byte_enable;
    logic [29:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_read_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    data_memory_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_width      (req_width),
        .req_unsigned   (req_unsigned),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_error     (resp_error),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_read_data  (mem_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("resp_data", resp_data, e[32:1]);
                chk("resp_error", {31'd0, resp_error}, {31'd0, e[0]});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready_stall"}, {30'd0, req_ready, stall}, 32'h2);
        chk({tag, "_resp"}, {31'd0, resp_valid} | {31'd0, resp_error} | resp_data, 32'd0);
        chk({tag, "_mem_ctl"}, {26'd0, mem_req, mem_we, mem_byte_enable}, 32'd0);
        chk({tag, "_mem_addr"}, {2'd0, mem_address}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    // Issue one access, act as the bus (grant after gd extra REQUEST cycles, rvalid rd cycles
    // after the grant cycle + 1) and check bus fields, latency from acceptance and stall.
    task automatic do_access(input string tag, input logic wr, input logic [1:0] w,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             input int gd, input int rd, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_data, input logic exp_err,
                             input int exp_lat, input logic exp_bus);
        int   reqcyc = 0;
        int   waitcyc = 0;
        logic granted = 1'b0;
        logic saw_req = 1'b0;
        logic done = 1'b0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid      = 1'b1;
        req_write      = wr;
        req_width      = w;
        req_unsigned   = uns;
        req_address    = addr;
        req_write_data = wd;
        sb_q.push_back({exp_data, exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (k == 1) chk({tag, "_stall_rise"}, {31'd0, stall}, 32'd1);
            if (resp_valid) begin
                chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
                chk({tag, "_mem_req_low"}, {31'd0, mem_req}, 32'd0);
                done = 1'b1;
                break;
            end
            if (mem_req) begin
                reqcyc++;
                if (!saw_req) begin
                    saw_req = 1'b1;
                    chk({tag, "_mem_addr"}, {2'd0, mem_address}, {2'd0, addr[31:2]});
                    chk({tag, "_mem_we_be"}, {27'd0, mem_we, mem_byte_enable}, {27'd0, wr, exp_be});
                    if (wr) chk({tag, "_mem_wdata"}, mem_write_data, exp_wd);
                end
                if (reqcyc == gd + 1) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end
            end else if (granted && !wr) begin
                waitcyc++;
                if (waitcyc == rd + 1) begin
                    mem_rvalid    = 1'b1;
                    mem_read_data = rdata;
                end
            end
        end
        if (!done) chk({tag, "_no_response"}, 32'd0, 32'd1);
        chk({tag, "_bus_used"}, {31'd0, saw_req}, {31'd0, exp_bus});
        @(negedge clk);
        chk({tag, "_stall_fall"}, {30'd0, stall, req_ready}, 32'h1);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_width      = 2'd0;
        req_unsigned   = 1'b0;
        req_address    = 32'd0;
        req_write_data = 32'd0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_read_data  = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        //        tag     wr  w     uns   addr          wdata          gd rd rdata          be       wdata_exp      data           err  lat bus
        do_access("sw",   1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b1);
        do_access("sb",   1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 2, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 4, 1'b1);
        do_access("sh",   1, 2'd1, 1'b0, 32'h102, 32'h00001234, 0, 0, 32'h0,        4'b1100, 32'h12341234, 32'h0,        1'b0, 2, 1'b1);
        do_access("lb",   0, 2'd0, 1'b0, 32'h103, 32'h0,        0, 0, 32'h80FF7F01, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1'b1);
        do_access("lbu",  0, 2'd0, 1'b1, 32'h103, 32'h0,        1, 1, 32'h80FF7F01, 4'b1000, 32'h0,        32'h00000080, 1'b0, 5, 1'b1);
        do_access("lb0",  0, 2'd0, 1'b0, 32'h100, 32'h0,        0, 0, 32'h80FF7F01, 4'b0001, 32'h0,        32'h00000001, 1'b0, 3, 1'b1);
        do_access("lh",   0, 2'd1, 1'b0, 32'h102, 32'h0,        0, 0, 32'h80FF7F01, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1'b1);
        do_access("lhu",  0, 2'd1, 1'b1, 32'h102, 32'h0,        0, 1, 32'h80FF7F01, 4'b1100, 32'h0,        32'h000080FF, 1'b0, 4, 1'b1);
        do_access("lw",   0, 2'd2, 1'b0, 32'h104, 32'h0,        0, 0, 32'h80FF7F01, 4'b1111, 32'h0,        32'h80FF7F01, 1'b0, 3, 1'b1);
        do_access("lw_mis", 0, 2'd2, 1'b0, 32'h102, 32'h0,      0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1, 1'b0);
        do_access("sh_mis", 1, 2'd1, 1'b0, 32'h101, 32'h5555,   0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1, 1'b0);
        do_access("w3_ill", 0, 2'd3, 1'b0, 32'h100, 32'h0,      0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1, 1'b0);
        do_access("gnt_last", 1, 2'd2, 1'b0, 32'h108, 32'h0BADF00D, 3, 0, 32'h0,    4'b1111, 32'h0BADF00D, 32'h0,        1'b0, 5, 1'b1);
        do_access("to_gnt", 1, 2'd2, 1'b0, 32'h10C, 32'h12345678, 99, 0, 32'h0,     4'b1111, 32'h12345678, 32'h0,        1'b1, 5, 1'b1);
        do_access("to_rv",  0, 2'd2, 1'b0, 32'h110, 32'h0,      0, 99, 32'h0,       4'b1111, 32'h0,        32'h0,        1'b1, 5, 1'b1);

        // Stray bus strobes while idle must be ignored.
        @(negedge clk);
        mem_rvalid    = 1'b1;
        mem_gnt       = 1'b1;
        mem_read_data = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        chk("stray_idle", {29'd0, resp_valid, mem_req, req_ready}, 32'h1);

        // Reset while waiting for load data: immediate abort, no response.
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_width   = 2'd2;
        req_address = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("abort_wait", {30'd0, stall, mem_req}, 32'h2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        do_access("post_rst", 0, 2'd0, 1'b1, 32'h201, 32'h0, 0, 0, 32'h11223344, 4'b0010, 32'h0, 32'h00000033, 1'b0, 3, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Load/store sequencer between the execute stage and the data memory port. Accepts one access per request (address, width, signedness, store data), drives a word-addressed, byte-enabled memory bus with a req/gnt/rvalid handshake, and returns aligned, extended load data to writeback. Detects misaligned or illegal accesses and bus timeouts. Stalls the pipeline while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles tolerated in REQUEST plus WAIT_DATA before an error abort. Legal range 2..255.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset. Asynchronous assert, active-low.
- `req_valid` input, 1 bit: execute stage presents an access.
- `req_ready` output, 1 bit: controller can accept an access.
- `req_write` input, 1 bit: 1 means store, 0 means load.
- `req_width` input, 2 bits: 0 is byte, 1 is half, 2 is word, 3 is illegal.
- `req_unsigned` input, 1 bit: zero-extend the load result (lbu, lhu).
- `req_address` input, 32 bits: byte address.
- `req_write_data` input, 32 bits: store data, right-aligned.
- `stall` output, 1 bit: an access is in progress.
- `resp_valid` output, 1 bit: one-cycle completion pulse.
- `resp_data` output, 32 bits: extended load data.
- `resp_error` output, 1 bit: this completion is misaligned, illegal or timed out.
- `mem_req` output, 1 bit: bus request.
- `mem_we` output, 1 bit: bus write.
- `mem_byte_enable` output, 4 bits: lane enables.
- `mem_address` output, 30 bits: word address, equal to `req_address[31:2]`.
- `mem_write_data` output, 32 bits: lane-replicated store data.
- `mem_gnt` input, 1 bit: bus accepted the request.
- `mem_rvalid` input, 1 bit: read data valid.
- `mem_read_data` input, 32 bits: read word.

## Operation
- **FSM states:** IDLE, REQUEST, WAIT_DATA, RESPOND.
  - `req_ready` = (state == IDLE).
  - `stall` = (state != IDLE).
- **Acceptance:** an access is accepted when `req_valid` and `req_ready` are both 1. All request fields are registered at that point.
- **Legality check at acceptance:**
  - Illegal if width is 3, or width is 1 with `addr[0]` = 1, or width is 2 with `addr[1:0]` ≠ 0.
  - Illegal access: go to RESPOND with the error flag set. No bus request is issued.
  - Legal access: go to REQUEST.
- **Byte enables:**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `addr[1]` = 1 gives `4'b1100`, otherwise `4'b0011`.
  - Word: `4'b1111`.
- **Store data:**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: unchanged.
- **REQUEST:**
  - `mem_req` = 1. `mem_we`, `mem_byte_enable`, `mem_address` and `mem_write_data` are held stable from registers.
  - On `mem_gnt`: a store goes to RESPOND; a load goes to WAIT_DATA.
- **WAIT_DATA:**
  - `mem_req` = 0.
  - On `mem_rvalid`, extract and register the load data, then go to RESPOND.
- **Load extraction:**
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
  - Sign-extend, or zero-extend when `req_unsigned` is set.
  - Word: passed through unchanged.
- **RESPOND:** `resp_valid` = 1 for exactly one cycle, then go to IDLE.
  - `resp_data` is the load result. It is 0 for stores and for errors.
  - `resp_error` is the registered error flag.
- **Timeout:**
  - An 8-bit counter clears on entry to REQUEST and increments each cycle spent in REQUEST or WAIT_DATA.
  - When it reaches `TIMEOUT_CYCLES - 1` without the awaited `mem_gnt` or `mem_rvalid`, go to RESPOND with error. `mem_req` drops the next cycle.
- **Ignored bus signals:**
  - `mem_rvalid` is ignored outside WAIT_DATA.
  - `mem_gnt` is ignored outside REQUEST.
- **Reset:** asserting `rst_n` mid-access aborts immediately. No response is produced.

## Timing
- **Reset values:**
  - state = IDLE.
  - `req_ready` = 1, `stall` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_error` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_byte_enable` = 0, `mem_address` = 0, `mem_write_data` = 0.
- **Store latency:** accepted at cycle N, `mem_req` high from N+1, grant at cycle G, `resp_valid` at G+1. With a same-cycle grant, the response is at N+2.
- **Load latency:** grant at G, `rvalid` at R ≥ G+1, `resp_valid` at R+1. The minimum is N+3.
- **Misaligned or illegal access:** `resp_valid` with error at N+1.
- **Back-to-back accesses:** the next access is accepted in the cycle after RESPOND, at the earliest.
- **Stall timing:** `stall` rises the cycle after acceptance and falls together with the exit from RESPOND.

## Test plan
- **sw:** sw `0xDEADBEEF` to `0x100`, `gnt` in the first REQUEST cycle → `mem_address` `0x40`, be `1111`, `we` = 1; `resp_valid` 2 cycles after acceptance with data 0 and error 0.
- **sb:** sb `0x000000A5` to `0x103` → be `1000`, `mem_write_data` `0xA5A5A5A5`.
- **lb / lbu / lh:** `mem_read_data` = `0x80FF7F01`:
  - lb at `0x103` → `0xFFFFFF80`.
  - lbu at `0x103` → `0x00000080`.
  - lh at `0x102` → `0xFFFF80FF`.
- **Misaligned:** lw at `0x102` or sh at `0x101` → no `mem_req`; `resp_valid` with error 1 at N+1.
- **Timeout:** `TIMEOUT_CYCLES` = 4, `gnt` held 0 → error response; `mem_req` low afterwards. A stray `mem_rvalid` in IDLE is ignored.
- **Reset mid-access:** assert `rst_n` low during WAIT_DATA → all outputs return to reset values immediately; the next access completes normally.
